dmem_rmw_port: RTL

- Next-generation data-memory port between the core's MEM stage and a synchronous single-port data RAM.
- Data width is parametrised and RAM read latency is configurable.
- Sub-word stores are handled internally as a sequenced read-modify-write, so the core no longer supplies a read-back word.
- Core side uses a valid/ready request and a one-cycle response pulse; one transaction is in flight at a time.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_lane_unit.sv | 53 +++++
 rtl/dmem_rmw_port.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types and helpers for the dmem_rmw_port data-memory port.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // Width of the byte offset inside one XLEN-wide RAM word.
  function automatic int laneOffW(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_unit.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_unit
// Brief    : Combinational byte-lane merge for sub-word stores and lane
//            extract with zero/sign extension for loads.
// Revision : 1.0
// ============================================================================
module dmem_lane_unit
  import dmem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = laneOffW(XLEN)
) (
  input  logic [OFFW-1:0] offset,
  input  logic [1:0]      size,
  input  logic            sext,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] mergedWord,
  output logic [XLEN-1:0] loadData
);

  localparam int c_NBYTES = XLEN / 8;

  int                  w_nBytes;
  int                  w_msb;
  logic [XLEN-1:0]     w_wShift;
  logic [XLEN-1:0]     w_rShift;
  logic [XLEN-1:0]     w_fieldMask;
  logic [c_NBYTES-1:0] w_laneSel;
  logic                w_signBit;

  always_comb begin
    w_nBytes = 1 << size;
    w_wShift = wdata << {offset, 3'b000};
    w_rShift = rdata >> {offset, 3'b000};
    w_laneSel = '0;
    for (int i = 0; i < c_NBYTES; i++)
      w_laneSel[i] = (i >= int'(offset)) && (i < int'(offset) + w_nBytes);
    w_fieldMask = '0;
    for (int i = 0; i < XLEN; i++)
      w_fieldMask[i] = (i < 8 * w_nBytes);
    // Clamp keeps the index legal for the unreachable dword-on-32-bit case.
    w_msb = (8 * w_nBytes > XLEN) ? XLEN - 1 : 8 * w_nBytes - 1;
    w_signBit = sext & w_rShift[w_msb];
    mergedWord = rdata;
    for (int i = 0; i < c_NBYTES; i++)
      if (w_laneSel[i]) mergedWord[8*i +: 8] = w_wShift[8*i +: 8];
    loadData = (w_rShift & w_fieldMask) | ({XLEN{w_signBit}} & ~w_fieldMask);
  end

endmodule
`default_nettype wire

// File: rtl/dmem_rmw_port.sv
`default_nettype none
// ============================================================================
// Module   : dmem_rmw_port
// Brief    : MEM-stage data port to a synchronous single-port RAM; sub-word
//            stores run as an internal read-modify-write.
//            DMEM_MISALIGN_TRAP_EN: misaligned accesses return an error.
// Revision : 1.0
// ============================================================================
module dmem_rmw_port
  import dmem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_rd,
  output logic              dm_wr,
  output logic [XLEN-1:0]   dm_wdata,
  input  logic [XLEN-1:0]   dm_rdata
);

  localparam int         c_OFFW    = laneOffW(XLEN);
  localparam int         c_LATW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [1:0] c_FULL_SZ = (XLEN == 64) ? SZ_D : SZ_W;

  state_t              r_state;
  logic [c_OFFW-1:0]   r_offset;
  logic [1:0]          r_size;
  logic                r_sext;
  logic                r_isLoad;
  logic [XLEN-1:0]     r_wdata;
  logic [c_LATW-1:0]   r_latCnt;

  logic [c_OFFW-1:0]   w_lowMask;
  logic [c_OFFW-1:0]   w_offset;
  logic [ADDR_W-1:0]   w_alignedAddr;
  logic                w_err;
  logic [XLEN-1:0]     w_merged;
  logic [XLEN-1:0]     w_loadData;

  always_comb begin
    w_lowMask = '0;
    for (int i = 0; i < c_OFFW; i++)
      w_lowMask[i] = (i < int'(req_size));
    w_offset      = req_addr[c_OFFW-1:0] & ~w_lowMask;
    w_alignedAddr = {req_addr[ADDR_W-1:c_OFFW], {c_OFFW{1'b0}}};
    w_err         = (req_rd == req_wr) || ((XLEN == 32) && (req_size == SZ_D));
`ifdef DMEM_MISALIGN_TRAP_EN
    w_err         = w_err || (|(req_addr[c_OFFW-1:0] & w_lowMask));
`endif
  end

  dmem_lane_unit #(
    .XLEN (XLEN),
    .OFFW (c_OFFW)
  ) u_lane (
    .offset     (r_offset),
    .size       (r_size),
    .sext       (r_sext),
    .wdata      (r_wdata),
    .rdata      (dm_rdata),
    .mergedWord (w_merged),
    .loadData   (w_loadData)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_offset   <= '0;
      r_size     <= SZ_B;
      r_sext     <= 1'b0;
      r_isLoad   <= 1'b0;
      r_wdata    <= '0;
      r_latCnt   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      dm_addr    <= '0;
      dm_rd      <= 1'b0;
      dm_wr      <= 1'b0;
      dm_wdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            r_offset  <= w_offset;
            r_size    <= req_size;
            r_sext    <= req_sext;
            r_wdata   <= req_wdata;
            r_isLoad  <= req_rd;
            if (w_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              r_state    <= ST_RESP;
            end else begin
              dm_addr <= w_alignedAddr;
              if (req_wr && (req_size == c_FULL_SZ)) begin
                dm_wr    <= 1'b1;
                dm_wdata <= req_wdata;
                r_state  <= ST_WR;
              end else begin
                dm_rd   <= 1'b1;
                r_state <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          dm_rd    <= 1'b0;
          r_latCnt <= c_LATW'(MEM_LAT - 1);
          r_state  <= ST_RD_WAIT;
        end
        // The last RD_WAIT cycle is the one where dm_rdata is valid.
        ST_RD_WAIT: begin
          if (r_latCnt != '0) begin
            r_latCnt <= r_latCnt - c_LATW'(1);
          end else if (r_isLoad) begin
            resp_valid <= 1'b1;
            resp_rdata <= w_loadData;
            r_state    <= ST_RESP;
          end else begin
            dm_wr    <= 1'b1;
            dm_wdata <= w_merged;
            r_state  <= ST_WR;
          end
        end
        ST_WR: begin
          dm_wr      <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
